// File: rtl/div_ctrl_pkg.sv
// div_ctrl_pkg: shared definitions for the multi-cycle divide sequencer.
//   RegBus / DoubleRegBus          : operand and result widths.
//   DivFree/DivByZero/DivOn/DivEnd : sequencer state encodings.
//   DivResultReady/NotReady        : ready_o levels.
//   DivStart/DivStop               : start_i levels.
package div_ctrl_pkg;

  localparam int RegBus       = 32;
  localparam int DoubleRegBus = 64;

  localparam logic [1:0] DivFree   = 2'b00;
  localparam logic [1:0] DivByZero = 2'b01;
  localparam logic [1:0] DivOn     = 2'b10;
  localparam logic [1:0] DivEnd    = 2'b11;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division iteration (combinational).
//   work_i    [64:0] : partial remainder in [64:33] region, quotient bits shift in at [0].
//   divisor_i [31:0] : divisor magnitude.
//   work_o    [64:0] : work register after one subtract/shift step.
module div_step
  import div_ctrl_pkg::*;
(
  input  logic [2*RegBus:0] work_i,
  input  logic [RegBus-1:0] divisor_i,
  output logic [2*RegBus:0] work_o
);

  logic [RegBus:0] diff;

  always_comb begin
    diff = work_i[2*RegBus:RegBus] - {1'b0, divisor_i};
    // A borrow out of the 33-bit subtract means the divisor did not fit:
    // shift in a 0 quotient bit and keep the old partial remainder.
    if (diff[RegBus]) begin
      work_o = {work_i[2*RegBus-1:0], 1'b0};
    end else begin
      work_o = {diff[RegBus-1:0], work_i[RegBus-1:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_ctrl.sv
// div_ctrl: multi-cycle divide sequencer (DIV / DIVU) for the EX stage.
//   clk, rst      : clock, synchronous active-high reset.
//   signed_div_i  : 1 = signed divide, sampled with the request.
//   opdata1_i     : dividend, opdata2_i : divisor (sampled with the request).
//   start_i       : request, held by EX until the result is consumed.
//   annul_i       : abandon the current or requested divide.
//   result_o      : {remainder, quotient}, valid while ready_o is high.
//   ready_o       : result valid.
//   div_zero_o    : divisor was zero; present only when DIV_ZERO_TRAP_EN is defined.
// A normal divide returns ready_o 34 cycles after the request is sampled;
// a zero divisor returns a zero result two cycles after the request.
module div_ctrl
  import div_ctrl_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    signed_div_i,
  input  logic [RegBus-1:0]       opdata1_i,
  input  logic [RegBus-1:0]       opdata2_i,
  input  logic                    start_i,
  input  logic                    annul_i,
  output logic [DoubleRegBus-1:0] result_o,
  output logic                    ready_o
`ifdef DIV_ZERO_TRAP_EN
  ,
  output logic                    div_zero_o
`endif
);

  logic [1:0]              state_q, state_d;
  logic [5:0]              cnt_q, cnt_d;
  logic [2*RegBus:0]       work_q, work_d, work_step;
  logic [RegBus-1:0]       divisor_q, divisor_d;
  logic                    neg_quot_q, neg_quot_d;
  logic                    neg_rem_q, neg_rem_d;
  logic [DoubleRegBus-1:0] result_q, result_d;
  logic                    ready_q, ready_d;

  function automatic logic [RegBus-1:0] neg_if(input logic [RegBus-1:0] v, input logic en);
    return en ? (~v + 32'd1) : v;
  endfunction

  div_step u_step (
    .work_i    (work_q),
    .divisor_i (divisor_q),
    .work_o    (work_step)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    work_d     = work_q;
    divisor_d  = divisor_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    result_d   = result_q;
    ready_d    = ready_q;
    case (state_q)
      DivFree: begin
        if (start_i == DivStart && !annul_i) begin
          if (opdata2_i == '0) begin
            state_d = DivByZero;
          end else begin
            // Divide magnitudes; signs are reapplied when the result is formed.
            divisor_d  = neg_if(opdata2_i, signed_div_i & opdata2_i[RegBus-1]);
            work_d     = {{RegBus{1'b0}},
                          neg_if(opdata1_i, signed_div_i & opdata1_i[RegBus-1]), 1'b0};
            neg_quot_d = signed_div_i & (opdata1_i[RegBus-1] ^ opdata2_i[RegBus-1]);
            neg_rem_d  = signed_div_i & opdata1_i[RegBus-1];
            cnt_d      = 6'd0;
            state_d    = DivOn;
          end
        end
      end
      DivByZero: begin
        result_d = '0;
        ready_d  = DivResultReady;
        state_d  = DivEnd;
      end
      DivOn: begin
        if (annul_i) begin
          result_d = '0;
          ready_d  = DivResultNotReady;
          state_d  = DivFree;
        end else if (cnt_q != 6'd32) begin
          work_d = work_step;
          cnt_d  = cnt_q + 6'd1;
        end else begin
          result_d = {neg_if(work_q[2*RegBus:RegBus+1], neg_rem_q),
                      neg_if(work_q[RegBus-1:0], neg_quot_q)};
          ready_d  = DivResultReady;
          state_d  = DivEnd;
        end
      end
      default: begin // DivEnd
        if (start_i == DivStop || annul_i) begin
          result_d = '0;
          ready_d  = DivResultNotReady;
          state_d  = DivFree;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= DivFree;
      cnt_q      <= 6'd0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= '0;
      ready_q    <= DivResultNotReady;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end

  // Datapath registers are always reloaded in FREE before use, so they carry no reset.
  always_ff @(posedge clk) begin
    work_q    <= work_d;
    divisor_q <= divisor_d;
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

`ifdef DIV_ZERO_TRAP_EN
  logic dz_q;

  // Set by the zero-divisor path, held only while END holds its result.
  always_ff @(posedge clk) begin
    if (rst) begin
      dz_q <= 1'b0;
    end else begin
      dz_q <= (state_q == DivByZero) |
              ((state_q == DivEnd) & (state_d == DivEnd) & dz_q);
    end
  end

  assign div_zero_o = dz_q;
`endif

endmodule
